serial_pattern_tx: RTL

//  Serial stimulus transmitter: accepts a parallel bit pattern via valid/ready and

---
 rtl/serial_tx_pkg.sv | 18 +
 rtl/tx_shreg.sv | 53 +++++
 rtl/serial_pattern_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM states, the
// default idle level of the serial line and gap-counter sizing.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic IDLE_LVL_DEFAULT = 1'b0;

  // The gap counter holds the number of gap cycles still to come (max GAP_CYC-1).
  function automatic int gap_cnt_width(input int gap_cyc);
    return (gap_cyc > 2) ? $clog2(gap_cyc) : 1;
  endfunction

endpackage

// File: rtl/tx_shreg.sv
// Pattern store with a down-counting bit index. sel_bit/last describe the bit
// that the next step would put on the line; a step past index 0 reloads pat_len.
module tx_shreg #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic             step,
  output logic             sel_bit,
  output logic             last
);

  logic [WIDTH-1:0] data_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] idx_reg;

  logic [WIDTH-1:0] data_src;
  logic [LEN_W-1:0] len_src;
  logic [LEN_W-1:0] idx_src;

  // A load bypasses the shadow registers so the first bit leaves on the accept edge.
  always_comb begin
    data_src = load ? data : data_reg;
    len_src  = load ? len  : len_reg;
    idx_src  = load ? len  : idx_reg;
  end

  assign sel_bit = data_src[idx_src];
  assign last    = (idx_src == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      len_reg  <= '0;
      idx_reg  <= '0;
    end else begin
      if (load) begin
        data_reg <= data;
        len_reg  <= len;
      end
      if (step) begin
        idx_reg <= last ? len_src : (idx_src - LEN_W'(1));
      end else if (load) begin
        idx_reg <= len;
      end
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial stimulus transmitter: loads a parallel pattern over valid/ready and
// sends it MSB-first on a_out, with optional repeats separated by idle gaps.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int   WIDTH    = 16,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 4,
  parameter int   GAP_CYC  = 2,
  parameter logic IDLE_LVL = IDLE_LVL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] pat_rep,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic             abort,
  output logic             a_out,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int               GAP_W    = gap_cnt_width(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_t           state_reg;
  logic [REP_W-1:0] rep_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             last_reg;
  logic             a_out_reg;
  logic             a_valid_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             pat_ready_reg;

  logic load;
  logic step;
  logic sel_bit;
  logic sel_last;

  // step means "a pattern bit goes on the line next cycle"; abort suppresses it.
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    if (!abort) begin
      unique case (state_reg)
        ST_IDLE: begin
          load = pat_valid;
          step = pat_valid;
        end
        ST_SHIFT: step = !last_reg || ((rep_cnt_reg != '0) && (GAP_CYC == 0));
        ST_GAP:   step = (gap_cnt_reg == '0);
        default:  step = 1'b0;
      endcase
    end
  end

  tx_shreg #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (pat_data),
    .len     (pat_len),
    .step    (step),
    .sel_bit (sel_bit),
    .last    (sel_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rep_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      last_reg      <= 1'b0;
      a_out_reg     <= IDLE_LVL;
      a_valid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pat_ready_reg <= 1'b1;
    end else begin
      a_out_reg   <= step ? sel_bit : IDLE_LVL;
      a_valid_reg <= step;
      done_reg    <= 1'b0;
      if (step) begin
        last_reg <= sel_last;
      end
      if (abort && (state_reg != ST_IDLE)) begin
        state_reg     <= ST_IDLE;
        rep_cnt_reg   <= '0;
        gap_cnt_reg   <= '0;
        busy_reg      <= 1'b0;
        pat_ready_reg <= 1'b1;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            if (load) begin
              state_reg     <= ST_SHIFT;
              rep_cnt_reg   <= pat_rep;
              busy_reg      <= 1'b1;
              pat_ready_reg <= 1'b0;
            end
          end
          ST_SHIFT: begin
            // last_reg marks that the bit now on the line closes a repetition.
            if (last_reg) begin
              if (rep_cnt_reg != '0) begin
                rep_cnt_reg <= rep_cnt_reg - REP_W'(1);
                gap_cnt_reg <= GAP_LOAD;
                state_reg   <= (GAP_CYC == 0) ? ST_SHIFT : ST_GAP;
              end else begin
                state_reg     <= ST_IDLE;
                busy_reg      <= 1'b0;
                pat_ready_reg <= 1'b1;
                done_reg      <= 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt_reg != '0) begin
              gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            end else begin
              state_reg <= ST_SHIFT;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign a_out     = a_out_reg;
  assign a_valid   = a_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign pat_ready = pat_ready_reg;

endmodule
